sram_port_arbiter: RTL and testbench

//  Shares one fakeram45_64x7 macro port between two requesters (e.g. two

---
 rtl/sram_port_arbiter_if.sv | 51 +++++
 rtl/sram_port_arbiter.sv | 118 +++++++++++
 tb/tb_sram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester handshakes, read responses and macro pins shared by
// sram_port_arbiter and whatever drives it. The slave modport is the
// arbiter's view. The master modport is the view of the requesters and the
// macro.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 7
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [DATA_W-1:0] req0_wmask;
    logic              req0_lock;
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [DATA_W-1:0] req1_wmask;
    logic              req1_lock;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wd;
    logic [DATA_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_rd;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wmask, req0_lock,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wmask, req1_lock,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output sram_ce, sram_we, sram_addr, sram_wd, sram_wmask,
        input  sram_rd
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_wmask, req0_lock,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_wmask, req1_lock,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  sram_ce, sram_we, sram_addr, sram_wd, sram_wmask,
        output sram_rd
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-requester round-robin arbiter in front of a single
// fakeram45_64x7 port. Read responses are tagged with the requester id and
// return RD_LAT cycles after the accept.
// Optional feature: define SRAM_ARB_LOCK_EN to let a requester hold the grant
// across accesses with reqN_lock.
module sram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 7,
    parameter int RD_LAT = 1   // 1..4
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port_arbiter_if.slave   bus
);

    logic              last_gnt;   // id of the most recent accept
    logic              rr0, rr1;   // round-robin grant before locking
    logic              gnt0, gnt1;
    logic              acc;        // an access goes to the macro this cycle
    logic              acc_id;     // 1 when requester 1 owns the access
    logic [RD_LAT:1]   vld_pipe;   // read in flight at each latency stage
    logic [RD_LAT:1]   id_pipe;    // requester tag riding alongside

    // A lone requester wins. On a tie the requester that did not go last wins.
    assign rr0 = bus.req0_valid & (~bus.req1_valid |  last_gnt);
    assign rr1 = bus.req1_valid & (~bus.req0_valid | ~last_gnt);

`ifdef SRAM_ARB_LOCK_EN
    logic locked;
    logic lock_owner;

    // While locked, the owner is the only requester that can be granted.
    // The other requester stays unready even if the owner is idle.
    assign gnt0 = locked ? (~lock_owner & bus.req0_valid) : rr0;
    assign gnt1 = locked ? ( lock_owner & bus.req1_valid) : rr1;

    // Track the lock. Only the owner can be accepted while locked, so any
    // accept with lock low releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (acc) begin
            if (acc_id ? bus.req1_lock : bus.req0_lock) begin
                locked     <= 1'b1;
                lock_owner <= acc_id;
            end else begin
                locked     <= 1'b0;
            end
        end
    end
`else
    assign gnt0 = rr0;
    assign gnt1 = rr1;

    wire unused_lock = bus.req0_lock ^ bus.req1_lock;
`endif

    // Nothing is accepted while reset is held.
    assign bus.req0_ready = gnt0 & ~rst;
    assign bus.req1_ready = gnt1 & ~rst;
    assign acc            = bus.req0_ready | bus.req1_ready;
    assign acc_id         = bus.req1_ready;

    // Route the accepted request straight to the macro pins. Drive them to
    // zero when idle.
    always_comb begin
        bus.sram_ce    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wd    = '0;
        bus.sram_wmask = '0;
        if (bus.req0_ready) begin
            bus.sram_ce    = 1'b1;
            bus.sram_we    = bus.req0_we;
            bus.sram_addr  = bus.req0_addr;
            bus.sram_wd    = bus.req0_wdata;
            bus.sram_wmask = bus.req0_wmask;
        end else if (bus.req1_ready) begin
            bus.sram_ce    = 1'b1;
            bus.sram_we    = bus.req1_we;
            bus.sram_addr  = bus.req1_addr;
            bus.sram_wd    = bus.req1_wdata;
            bus.sram_wmask = bus.req1_wmask;
        end
    end

    // Remember who went last so that ties alternate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_gnt <= 1'b1;
        else if (acc)
            last_gnt <= acc_id;
    end

    // Shift accepted reads toward the macro's data-valid cycle. Reset drops
    // anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= acc & ~bus.sram_we;
            id_pipe[1]  <= acc_id;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    // At pipe exit the macro's rd_out belongs to the tagged requester.
    assign bus.rsp0_valid = vld_pipe[RD_LAT] & ~id_pipe[RD_LAT];
    assign bus.rsp1_valid = vld_pipe[RD_LAT] &  id_pipe[RD_LAT];
    assign bus.rsp0_rdata = bus.rsp0_valid ? bus.sram_rd : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? bus.sram_rd : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter. A behavioural 64x7 macro sits on the sram
// pins. A transaction-level model predicts grants, macro pin values and
// tagged responses from the arbitration rules.
module tb_sram_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 7;
    localparam int RD_LAT = 1;

    logic clk;
    logic rst;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: synchronous masked write, read data RD_LAT edges later.
    logic [DATA_W-1:0] mem   [64];
    logic [DATA_W-1:0] rdpipe[RD_LAT];
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rdpipe[i] <= rdpipe[i-1];
        if (bus.sram_ce) begin
            if (bus.sram_we)
                mem[bus.sram_addr] <= (mem[bus.sram_addr] & ~bus.sram_wmask) |
                                      (bus.sram_wd & bus.sram_wmask);
            else
                rdpipe[0] <= mem[bus.sram_addr];
        end
    end
    assign bus.sram_rd = rdpipe[RD_LAT-1];

    // Reference model state.
    typedef struct {
        int               id;
        logic [DATA_W-1:0] data;
        int               due;
    } exp_t;
    exp_t              q[$];
    logic [DATA_W-1:0] ref_mem[64];
    logic              m_last;
    logic              m_locked;
    logic              m_owner;
    logic              m_g0, m_g1;
    logic              obs_rdy1;
    logic [DATA_W-1:0] last_rsp0, last_rsp1;
    int                cyc, n_rsp0, n_rsp1;
    int                tests, fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set0(input logic v, input logic we, input logic [5:0] a,
                        input logic [6:0] wd, input logic [6:0] wm, input logic lk);
        bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a;
        bus.req0_wdata = wd; bus.req0_wmask = wm; bus.req0_lock = lk;
    endtask

    task automatic set1(input logic v, input logic we, input logic [5:0] a,
                        input logic [6:0] wd, input logic [6:0] wm, input logic lk);
        bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a;
        bus.req1_wdata = wd; bus.req1_wmask = wm; bus.req1_lock = lk;
    endtask

    task automatic model_reset();
        q.delete();
        m_last   = 1'b1;
        m_locked = 1'b0;
        m_owner  = 1'b0;
    endtask

    // One clock: predict, compare at the falling edge, advance the model,
    // then return just after the next rising edge.
    task automatic step();
        logic g0, g1, ev0, ev1, ece, ewe, id, lk;
        logic [5:0] ea;
        logic [6:0] ewd, ewm, ed0, ed1;
        @(negedge clk);
        g0 = 1'b0; g1 = 1'b0;
        if (!rst) begin
`ifdef SRAM_ARB_LOCK_EN
            if (m_locked) begin
                g0 = !m_owner && bus.req0_valid;
                g1 =  m_owner && bus.req1_valid;
            end else
`endif
            if (bus.req0_valid && bus.req1_valid) begin
                g0 = m_last;
                g1 = !m_last;
            end else begin
                g0 = bus.req0_valid;
                g1 = bus.req1_valid;
            end
        end
        ece = g0 | g1;
        ewe = 1'b0; ea = '0; ewd = '0; ewm = '0; lk = 1'b0;
        if (g0) begin
            ewe = bus.req0_we; ea = bus.req0_addr; ewd = bus.req0_wdata;
            ewm = bus.req0_wmask; lk = bus.req0_lock;
        end else if (g1) begin
            ewe = bus.req1_we; ea = bus.req1_addr; ewd = bus.req1_wdata;
            ewm = bus.req1_wmask; lk = bus.req1_lock;
        end
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].id == 0) begin ev0 = 1'b1; ed0 = q[0].data; end
            else              begin ev1 = 1'b1; ed1 = q[0].data; end
            void'(q.pop_front());
        end
        chk("ready0",     32'(bus.req0_ready), 32'(g0));
        chk("ready1",     32'(bus.req1_ready), 32'(g1));
        chk("sram_ce",    32'(bus.sram_ce),    32'(ece));
        chk("sram_we",    32'(bus.sram_we),    32'(ewe));
        chk("sram_addr",  32'(bus.sram_addr),  32'(ea));
        chk("sram_wd",    32'(bus.sram_wd),    32'(ewd));
        chk("sram_wmask", 32'(bus.sram_wmask), 32'(ewm));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(ev0));
        chk("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(ed0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(ev1));
        chk("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(ed1));
        obs_rdy1 = bus.req1_ready;
        if (bus.rsp0_valid === 1'b1) begin n_rsp0++; last_rsp0 = bus.rsp0_rdata; end
        if (bus.rsp1_valid === 1'b1) begin n_rsp1++; last_rsp1 = bus.rsp1_rdata; end
        if (ece) begin
            id = g1;
            if (ewe) ref_mem[ea] = (ref_mem[ea] & ~ewm) | (ewd & ewm);
            else     q.push_back('{int'(id), ref_mem[ea], cyc + RD_LAT});
            m_last = id;
`ifdef SRAM_ARB_LOCK_EN
            if (lk) begin m_locked = 1'b1; m_owner = id; end
            else        m_locked = 1'b0;
`else
            if (lk) begin end
`endif
        end
        m_g0 = g0; m_g1 = g1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, c1, rdy_cnt;
        tests = 0; fails = 0; cyc = 0; n_rsp0 = 0; n_rsp1 = 0;
        last_rsp0 = '0; last_rsp1 = '0;
        model_reset();

        // Reset held with both requesters valid: nothing may be granted.
        rst = 1'b1;
        set0(1, 0, 6'd1, 7'h0, 7'h0, 0);
        set1(1, 0, 6'd2, 7'h0, 7'h0, 0);
        #1;
        step();
        step();
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
        chk("rst_ce",     32'(bus.sram_ce),    32'd0);
        rst = 1'b0;
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);

        // Preload every word through requester 0 with a full mask.
        for (int a = 0; a < 64; a++) begin
            logic [6:0] d;
            d = 7'($urandom);
            if (a == 5)  d = 7'h2A;
            if (a == 63) d = 7'h00;
            set0(1, 1, 6'(a), d, 7'h7F, 0);
            step();
        end
        set0(0, 0, 0, 0, 0, 0);

        // Single read of word 5.
        set0(1, 0, 6'd5, 7'h0, 7'h0, 0);
        step();
        set0(0, 0, 0, 0, 0, 0);
        c1 = n_rsp1;
        step();
        chk("single_rdata", 32'(last_rsp0), 32'h2A);
        chk("single_no_rsp1", 32'(n_rsp1 - c1), 32'd0);

        // Twenty cycles of contention.
        c0 = n_rsp0; c1 = n_rsp1;
        set0(1, 0, 6'd1, 7'h0, 7'h0, 0);
        set1(1, 0, 6'd2, 7'h0, 7'h0, 0);
        for (int i = 0; i < 20; i++) step();
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("cont_rsp0_cnt", 32'(n_rsp0 - c0), 32'd10);
        chk("cont_rsp1_cnt", 32'(n_rsp1 - c1), 32'd10);

        // Masked write over zero, then read back.
        set1(1, 1, 6'd63, 7'h7F, 7'h0F, 0);
        step();
        set1(1, 0, 6'd63, 7'h00, 7'h00, 0);
        step();
        set1(0, 0, 0, 0, 0, 0);
        step();
        chk("mask_rdata", 32'(last_rsp1), 32'h0F);

        // A reset while a read is in flight drops that read.
        set0(1, 0, 6'd7, 7'h0, 7'h0, 0);
        step();
        set0(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_rsp0", 32'(bus.rsp0_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        set0(1, 0, 6'd3, 7'h0, 7'h0, 0);
        set1(1, 0, 6'd4, 7'h0, 7'h0, 0);
        #1;
        chk("post_rst_tie", 32'(bus.req0_ready), 32'd1);
        step();
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        step();

        // Random traffic. Each request is held until it is accepted.
        for (int i = 0; i < 400; i++) begin
            if (!bus.req0_valid || m_g0)
                set0($urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom_range(0, 7)),
                     7'($urandom), 7'($urandom), $urandom_range(0, 3) == 0);
            if (!bus.req1_valid || m_g1)
                set1($urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom_range(0, 7)),
                     7'($urandom), 7'($urandom), $urandom_range(0, 3) == 0);
            step();
        end
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        // Requester 0 accesses with lock high three times, then low once.
        // Requester 1 stays valid throughout.
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        rdy_cnt = 0;
        set1(1, 0, 6'd2, 7'h0, 7'h0, 0);
        for (int i = 0; i < 4; i++) begin
            set0(1, 0, 6'd1, 7'h0, 7'h0, i < 3);
            step();
            if (obs_rdy1) rdy_cnt++;
        end
        set0(1, 0, 6'd1, 7'h0, 7'h0, 0);
        step();
`ifdef SRAM_ARB_LOCK_EN
        chk("lock_rdy1_cnt", 32'(rdy_cnt), 32'd0);
        chk("lock_after",    32'(obs_rdy1), 32'd1);
`else
        chk("lock_rdy1_cnt", 32'(rdy_cnt), 32'd2);
        chk("lock_after",    32'(obs_rdy1), 32'd0);
`endif
        set0(0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
